// File: rtl/axis_mesh_link_nch.sv
// Inter-router link stage: NUM_CHANNELS independent AXI-Stream FIFOs with
// per-channel saturating packet/beat/stall counters.
module axis_mesh_link_nch #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int DEST_WIDTH   = 4,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_CHANNELS-1:0]            s_tvalid_i,
    output logic [NUM_CHANNELS-1:0]            s_tready_o,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_CHANNELS-1:0]            s_tlast_i,
    input  logic [NUM_CHANNELS*ID_WIDTH-1:0]   s_tid_i,
    input  logic [NUM_CHANNELS*DEST_WIDTH-1:0] s_tdest_i,
    output logic [NUM_CHANNELS-1:0]            m_tvalid_o,
    input  logic [NUM_CHANNELS-1:0]            m_tready_i,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_tdata_o,
    output logic [NUM_CHANNELS-1:0]            m_tlast_o,
    output logic [NUM_CHANNELS*ID_WIDTH-1:0]   m_tid_o,
    output logic [NUM_CHANNELS*DEST_WIDTH-1:0] m_tdest_o,
    input  logic                               cnt_clear_i,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  beat_cnt_o,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = DATA_WIDTH + 1 + ID_WIDTH + DEST_WIDTH;
    localparam logic [PTR_W-1:0]     FULL_OCC = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [ENT_W-1:0]     mem [DEPTH];
        logic [PTR_W-1:0]     wr_ptr, rd_ptr, occ;
        logic                 push, pop;
        logic [ENT_W-1:0]     head;
        logic [CNT_WIDTH-1:0] pkt_cnt, beat_cnt, stall_cnt;

        // Ready comes from occupancy only, so a same-cycle pop never frees a full FIFO.
        assign s_tready_o[c] = (occ != FULL_OCC) && !rst_i;
        assign m_tvalid_o[c] = (occ != '0);
        assign push          = s_tvalid_i[c] && s_tready_o[c];
        assign pop           = m_tvalid_o[c] && m_tready_i[c];

        assign head = mem[rd_ptr[PTR_W-2:0]];
        assign {m_tdata_o[c*DATA_WIDTH +: DATA_WIDTH], m_tlast_o[c],
                m_tid_o[c*ID_WIDTH +: ID_WIDTH], m_tdest_o[c*DEST_WIDTH +: DEST_WIDTH]} = head;

        assign pkt_cnt_o[c*CNT_WIDTH +: CNT_WIDTH]   = pkt_cnt;
        assign beat_cnt_o[c*CNT_WIDTH +: CNT_WIDTH]  = beat_cnt;
        assign stall_cnt_o[c*CNT_WIDTH +: CNT_WIDTH] = stall_cnt;

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_ptr[PTR_W-2:0]] <= {s_tdata_i[c*DATA_WIDTH +: DATA_WIDTH], s_tlast_i[c],
                                           s_tid_i[c*ID_WIDTH +: ID_WIDTH],
                                           s_tdest_i[c*DEST_WIDTH +: DEST_WIDTH]};
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
                if (push && !pop)      occ <= occ + PTR_W'(1);
                else if (!push && pop) occ <= occ - PTR_W'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pkt_cnt   <= '0;
                beat_cnt  <= '0;
                stall_cnt <= '0;
            end else if (cnt_clear_i) begin
                pkt_cnt   <= '0;
                beat_cnt  <= '0;
                stall_cnt <= '0;
            end else begin
                if (pop && beat_cnt != CNT_MAX)
                    beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                if (pop && m_tlast_o[c] && pkt_cnt != CNT_MAX)
                    pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                if (m_tvalid_o[c] && !m_tready_i[c] && stall_cnt != CNT_MAX)
                    stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_mesh_link_nch.sv
// Directed bench for axis_mesh_link_nch: a 2-channel instance plus a
// 1-channel instance with 2-bit counters for saturation.
module tb_axis_mesh_link_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [63:0] s_tdata, m_tdata;
    logic [7:0]  s_tid, s_tdest, m_tid, m_tdest;
    logic        cnt_clear;
    logic [31:0] pkt_cnt, beat_cnt, stall_cnt;

    logic        sat_s_tvalid, sat_s_tready, sat_s_tlast, sat_m_tvalid, sat_m_tready, sat_m_tlast;
    logic [31:0] sat_s_tdata, sat_m_tdata;
    logic [3:0]  sat_s_tid, sat_s_tdest, sat_m_tid, sat_m_tdest;
    logic        sat_clear;
    logic [1:0]  sat_pkt, sat_beat, sat_stall;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    axis_mesh_link_nch #(.NUM_CHANNELS(2), .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4),
                         .DEPTH(4), .CNT_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
        .s_tlast_i(s_tlast), .s_tid_i(s_tid), .s_tdest_i(s_tdest),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata),
        .m_tlast_o(m_tlast), .m_tid_o(m_tid), .m_tdest_o(m_tdest),
        .cnt_clear_i(cnt_clear), .pkt_cnt_o(pkt_cnt), .beat_cnt_o(beat_cnt),
        .stall_cnt_o(stall_cnt)
    );

    axis_mesh_link_nch #(.NUM_CHANNELS(1), .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4),
                         .DEPTH(4), .CNT_WIDTH(2)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .s_tvalid_i(sat_s_tvalid), .s_tready_o(sat_s_tready), .s_tdata_i(sat_s_tdata),
        .s_tlast_i(sat_s_tlast), .s_tid_i(sat_s_tid), .s_tdest_i(sat_s_tdest),
        .m_tvalid_o(sat_m_tvalid), .m_tready_i(sat_m_tready), .m_tdata_o(sat_m_tdata),
        .m_tlast_o(sat_m_tlast), .m_tid_o(sat_m_tid), .m_tdest_o(sat_m_tdest),
        .cnt_clear_i(sat_clear), .pkt_cnt_o(sat_pkt), .beat_cnt_o(sat_beat),
        .stall_cnt_o(sat_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sent, recv, cyc;
        logic [40:0] exp_beat;

        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tid = '0; s_tdest = '0;
        m_tready = '0; cnt_clear = 1'b0;
        sat_s_tvalid = 1'b0; sat_s_tdata = '0; sat_s_tlast = 1'b0; sat_s_tid = '0;
        sat_s_tdest = '0; sat_m_tready = 1'b0; sat_clear = 1'b0;

        // Reset state
        #12;
        chk("rst_s_tready", s_tready, 2'b00);
        chk("rst_m_tvalid", m_tvalid, 2'b00);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_beat", beat_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 2'b11);

        // Single beat through ch0
        m_tready = 2'b11;
        s_tvalid[0] = 1'b1; s_tdata[31:0] = 32'hA5A5_A5A5; s_tlast[0] = 1'b1;
        s_tid[3:0] = 4'd3; s_tdest[3:0] = 4'd5;
        chk("single_pre_valid", m_tvalid[0], 1'b0);
        @(negedge clk);
        s_tvalid[0] = 1'b0;
        chk("single_valid", m_tvalid[0], 1'b1);
        chk("single_fields", {m_tdata[31:0], m_tlast[0], m_tid[3:0], m_tdest[3:0]},
            {32'hA5A5_A5A5, 1'b1, 4'd3, 4'd5});
        @(negedge clk);
        chk("single_gone", m_tvalid[0], 1'b0);
        chk("single_pkt", pkt_cnt[15:0], 16'd1);
        chk("single_beat", beat_cnt[15:0], 16'd1);
        chk("single_stall", stall_cnt[15:0], 16'd0);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        chk("clear_pkt", pkt_cnt, 0);
        chk("clear_beat", beat_cnt, 0);
        m_tready[0] = 1'b0;

        // Fill ch0 with downstream stalled
        for (int unsigned k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("fill_s_tready", s_tready[0], (k < 4) ? 1'b1 : 1'b0);
            chk("fill_stall", stall_cnt[15:0], (k > 0) ? 16'(k - 1) : 16'd0);
            s_tvalid[0] = 1'b1;
            s_tdata[31:0] = 32'h100 + k;
            s_tlast[0] = (k == 3);
        end
        @(negedge clk);
        s_tvalid[0] = 1'b0;
        chk("fill_stall_end", stall_cnt[15:0], 16'd6);
        chk("fill_full", s_tready[0], 1'b0);
        chk("fill_head", m_tdata[31:0], 32'h100);

        // Random stream on ch1 while ch0 held full
        sent = 0; recv = 0; cyc = 0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            m_tready[1] = ($urandom_range(0, 3) != 0);
            s_tvalid[1] = (sent < 100) && ($urandom_range(0, 2) != 0);
            s_tdata[63:32] = 32'hC000_0000 + 32'(sent * 7);
            s_tlast[1] = ((sent % 5) == 4);
            s_tid[7:4] = 4'(sent);
            s_tdest[7:4] = 4'(sent * 3);
            if (s_tvalid[1] && s_tready[1]) sent++;
            if (m_tvalid[1] && m_tready[1]) begin
                exp_beat = {32'hC000_0000 + 32'(recv * 7), ((recv % 5) == 4), 4'(recv), 4'(recv * 3)};
                chk("ch1_stream", {m_tdata[63:32], m_tlast[1], m_tid[7:4], m_tdest[7:4]}, exp_beat);
                recv++;
            end
        end
        chk("ch1_stream_done", recv, 100);
        @(negedge clk);
        s_tvalid[1] = 1'b0;
        m_tready[1] = 1'b0;
        chk("ch1_pkt", pkt_cnt[31:16], 16'd20);
        chk("ch1_beat", beat_cnt[31:16], 16'd100);
        chk("ch0_still_full", {s_tready[0], m_tvalid[0]}, 2'b01);
        chk("ch0_head_kept", m_tdata[31:0], 32'h100);
        chk("ch0_beat_idle", beat_cnt[15:0], 16'd0);

        // Drain ch0 in order
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            m_tready[0] = 1'b1;
            chk("drain_valid", m_tvalid[0], 1'b1);
            chk("drain_data", {m_tdata[31:0], m_tlast[0]}, {32'h100 + i, (i == 3)});
        end
        @(negedge clk);
        chk("drain_empty", m_tvalid[0], 1'b0);
        chk("drain_beat", beat_cnt[15:0], 16'd4);
        chk("drain_pkt", pkt_cnt[15:0], 16'd1);

        // Pointer wrap: push and pop every cycle
        for (int unsigned k = 0; k < 13; k++) begin
            if (k > 0) begin
                chk("wrap_valid", {m_tvalid[0], s_tready[0]}, 2'b11);
                chk("wrap_data", m_tdata[31:0], 32'h200 + k - 1);
            end
            s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0;
            s_tdata[31:0] = 32'h200 + k;
            @(negedge clk);
        end
        s_tvalid[0] = 1'b0;
        chk("wrap_last", {m_tvalid[0], m_tdata[31:0]}, {1'b1, 32'h20C});
        @(negedge clk);
        chk("wrap_empty", m_tvalid[0], 1'b0);

        // Saturation on 2-bit counters, then clear coincident with pop
        sat_m_tready = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            sat_s_tvalid = 1'b1; sat_s_tlast = 1'b1; sat_s_tdata = 32'(k);
            @(negedge clk);
        end
        sat_s_tvalid = 1'b0;
        @(negedge clk);
        chk("sat_pkt", sat_pkt, 2'd3);
        chk("sat_beat", sat_beat, 2'd3);
        sat_s_tvalid = 1'b1;
        @(negedge clk);
        sat_s_tvalid = 1'b0;
        chk("sat_pop_pending", sat_m_tvalid, 1'b1);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        chk("sat_clear_pkt", sat_pkt, 2'd0);
        chk("sat_clear_beat", sat_beat, 2'd0);

        // Reset mid-packet on ch1
        m_tready[1] = 1'b0;
        s_tvalid[1] = 1'b1; s_tlast[1] = 1'b0;
        s_tdata[63:32] = 32'hDEAD_0001;
        @(negedge clk);
        s_tdata[63:32] = 32'hDEAD_0002;
        @(negedge clk);
        s_tvalid[1] = 1'b0;
        chk("mid_pkt_valid", m_tvalid[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_m_tvalid", m_tvalid, 2'b00);
        chk("async_rst_s_tready", s_tready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_s_tready", s_tready, 2'b11);
        chk("after_rst_m_tvalid", m_tvalid, 2'b00);
        chk("after_rst_cnts", {pkt_cnt, beat_cnt, stall_cnt[15:0]}, 0);
        m_tready = 2'b11;
        @(negedge clk);
        chk("after_rst_stays_empty", m_tvalid, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_mesh_link_nch.md
# axis_mesh_link_nch

Parametrised inter-router link stage for the XY mesh. It carries NUM_CHANNELS independent AXI-Stream networks in parallel, generalising the fixed req/resp pair, and gives each channel its own DEPTH-entry FIFO. This breaks long router-to-router paths in both directions. Each channel also has per-channel PMU counters for packets, beats and downstream stall cycles. One instance sits on each directed router-to-router edge of the mesh.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of parallel AXI-Stream networks (>=1)
- DATA_WIDTH, 32, TDATA width per channel (multiple of 8)
- ID_WIDTH, 4, TID width per channel
- DEST_WIDTH, 4, TDEST width per channel
- DEPTH, 4, FIFO entries per channel (power of 2, >=2)
- CNT_WIDTH, 16, PMU counter width (>=2)

Ports:
- clk_i  in  1  link clock
- rst_i  in  1  asynchronous, active-high reset
- s_tvalid_i  in  NUM_CHANNELS  upstream valid, bit c = channel c
- s_tready_o  out  NUM_CHANNELS  upstream ready
- s_tdata_i  in  NUM_CHANNELS*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- s_tlast_i  in  NUM_CHANNELS  end of packet
- s_tid_i  in  NUM_CHANNELS*ID_WIDTH  packed like tdata
- s_tdest_i  in  NUM_CHANNELS*DEST_WIDTH  packed like tdata
- m_tvalid_o, m_tready_i, m_tdata_o, m_tlast_o, m_tid_o, m_tdest_o  out/in/out/out/out/out  same widths  downstream side
- cnt_clear_i  in  1  synchronous clear of all PMU counters
- pkt_cnt_o  out  NUM_CHANNELS*CNT_WIDTH  packets forwarded per channel
- beat_cnt_o  out  NUM_CHANNELS*CNT_WIDTH  beats forwarded per channel
- stall_cnt_o  out  NUM_CHANNELS*CNT_WIDTH  cycles with m_tvalid=1 and m_tready=0

## Operation
- Channels are fully independent. The only shared items are the clock, the reset and cnt_clear_i.
- Per channel: circular FIFO of DEPTH entries with {tdata, tlast, tid, tdest}.
  - Write pointer, read pointer and occupancy counter are each of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Push = s_tvalid & s_tready. Pop = m_tvalid & m_tready.
- s_tready = (occupancy != DEPTH) and not in reset. It depends only on registered state.
- m_tvalid = (occupancy != 0). m_tdata/tlast/tid/tdest come from the head entry, driven directly from storage.
- Push and pop in the same cycle leave occupancy unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- When full, s_tready=0 even if a pop occurs that cycle. There is no pass-through from m_tready to s_tready.
- Beats are never reordered, dropped or duplicated. TLAST, TID and TDEST travel unchanged with their beat.
- Held m_* outputs stay stable while m_tvalid=1 and m_tready=0, as AXI-Stream requires.
- PMU counters, per channel:
  - beat_cnt +1 on each pop.
  - pkt_cnt +1 on each pop with tlast=1.
  - stall_cnt +1 on each cycle with m_tvalid=1 and m_tready=0.
  - All counters saturate at 2^CNT_WIDTH-1 and do not wrap.
  - cnt_clear_i=1 zeroes every counter at the next edge and takes priority over any increment in that cycle.
- Reset: all FIFOs empty, all counters 0. Stored data is not cleared; it is don't-care.

## Timing
- Reset values: s_tready_o=0 while rst_i=1, then all 1 from the first cycle after release. m_tvalid_o=0, counters 0, m_tdata/tlast/tid/tdest undefined.
- Latency: a beat accepted at edge N is presented with m_tvalid=1 in the cycle after edge N. That is 1 cycle through an empty FIFO.
- Throughput: 1 beat/cycle/channel sustained when m_tready is held 1.
- Backpressure: with m_tready=0, s_tready falls in the cycle after the DEPTH-th accepted beat.
- Counters update at the same edge as the event. Outputs are registered.
- rst_i asserted mid-packet: the channel empties immediately (asynchronously). Any partial packet is discarded. Upstream must restart packets after release.
- No combinational path from any s_* input to any m_* output, or from m_tready_i to s_tready_o.

## Test plan
- Single beat, ch0, tdata=0xA5A5A5A5, tlast=1, tid=3, tdest=5, m_tready=1 -> m_tvalid high exactly 1 cycle after acceptance with identical fields. Counters end at pkt=1, beat=1, stall=0.
- Fill, DEPTH=4, m_tready=0, s_tvalid=1 continuously -> exactly 4 beats accepted and s_tready=0 from then on. stall_cnt increments every cycle. Releasing m_tready drains 4 beats in order.
- Streaming 100 beats, packets of 5, with random s_tvalid and m_tready on ch1 while ch0 is held full -> ch1 output matches input in order. pkt_cnt[1]=20, beat_cnt[1]=100. ch0 state is unaffected.
- Pointer wrap: 3*DEPTH+1 beats with push and pop every cycle -> data order intact and occupancy stays at 1.
- CNT_WIDTH=2: 6 packets -> pkt_cnt saturates at 3. Raising cnt_clear_i in the same cycle as a pop -> counter reads 0 the next cycle.
- rst_i pulsed with 2 beats queued mid-packet -> m_tvalid=0 and s_tready=0 immediately. After release s_tready=1, m_tvalid stays 0 and counters read 0.
